// File: rtl/n1s_n0s_pkg.sv
// n1s_n0s_pkg -- sequencer state encoding and default run width, shared with the detector bench.
// Rev 1.0
`default_nettype none

package n1s_n0s_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/n1s_n0s_seq_if.sv
// n1s_n0s_seq_if -- run-control and detector-facing signal bundle of the sequencer.
// Rev 1.0
`default_nettype none

interface n1s_n0s_seq_if #(
  parameter int WIDTH = n1s_n0s_pkg::WIDTH_DEFAULT
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             start;
  logic [3:0]       n_in;
  logic [WIDTH-1:0] pattern;
  logic             led_in;
  logic [3:0]       n;
  logic             save;
  logic             w;
  logic             busy;
  logic             done;
  logic             err;
  logic [CW-1:0]    hit_count;

  modport master (
    output start, n_in, pattern, led_in,
    input  n, save, w, busy, done, err, hit_count
  );

  modport slave (
    input  start, n_in, pattern, led_in,
    output n, save, w, busy, done, err, hit_count
  );

endinterface

`default_nettype wire

// File: rtl/n1s_n0s_seq_piso.sv
// piso_shift -- parallel-in serial-out register with load and shift enables, MSB first.
// Rev 1.0
`default_nettype none

module piso_shift #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] din,
  output logic                  sout,
  output logic                  sout_next
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  // sout_next lets the owner register the bit that becomes MSB after this shift
  assign sout      = q[WIDTH-1];
  assign sout_next = q[WIDTH-2];

endmodule

`default_nettype wire

// File: rtl/n1s_n0s_seq.sv
// n1s_n0s_seq -- configures a run-length detector, streams a pattern into it and counts its hits.
// Rev 1.0
`default_nettype none

module n1s_n0s_seq
  import n1s_n0s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  n1s_n0s_seq_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] HIT_MAX  = CW'(WIDTH);

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   hits;
  logic [3:0]      n_reg;
  logic            save_reg;
  logic            w_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic            accept;
  logic            shift_en;
  logic            count_en;
  logic            ser_msb;
  logic            ser_next;

  assign accept   = (state == S_IDLE) && bus.start && (bus.n_in != 4'd0);
  assign shift_en = (state == S_SHIFT);
  // led_in trails w by one cycle, so SHIFT cycle 0 still shows stale detector state
  assign count_en = bus.led_in &&
                    (((state == S_SHIFT) && (bit_cnt != '0)) || (state == S_DRAIN));

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (shift_en),
    .din       (bus.pattern),
    .sout      (ser_msb),
    .sout_next (ser_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      hits     <= '0;
      n_reg    <= 4'd0;
      save_reg <= 1'b0;
      w_reg    <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      save_reg <= 1'b0;
      done_reg <= 1'b0;
      if (count_en && (hits != HIT_MAX)) begin
        hits <= hits + 1'b1;
      end
      case (state)
        S_IDLE: begin
          w_reg <= 1'b0;
          if (bus.start) begin
            busy_reg <= 1'b1;
            hits     <= '0;
            if (bus.n_in != 4'd0) begin
              n_reg    <= bus.n_in;
              err_reg  <= 1'b0;
              save_reg <= 1'b1;
              state    <= S_CONFIG;
            end else begin
              err_reg  <= 1'b1;
              done_reg <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_CONFIG: begin
          bit_cnt <= '0;
          w_reg   <= ser_msb;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            w_reg <= 1'b0;
            state <= S_DRAIN;
          end else begin
            w_reg <= ser_next;
          end
        end
        S_DRAIN: begin
          done_reg <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          busy_reg <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          w_reg    <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.n         = n_reg;
  assign bus.save      = save_reg;
  assign bus.w         = w_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.hit_count = hits;

endmodule

`default_nettype wire

// File: tb/tb_n1s_n0s_seq.sv
// tb_n1s_n0s_seq -- cycle model plus directed runs against an n-ones-then-n-zeros reference detector.
// Rev 1.0
`default_nettype none

module tb_n1s_n0s_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic force_led = 1'b0;
  logic det_led;

  int n_vec = 0;
  int n_mis = 0;

  n1s_n0s_seq_if #(.WIDTH(W)) bus ();

  n1s_n0s_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.led_in = force_led | det_led;

  // Reference detector: after >= n consecutive ones, flags each of the next n zeros.
  int ones, zc;
  logic phase;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.save) begin
      ones <= 0; zc <= 0; phase <= 1'b0; det_led <= 1'b0;
    end else if (bus.w) begin
      ones <= ones + 1; zc <= 0; phase <= 1'b0; det_led <= 1'b0;
    end else if (bus.n != 4'd0 && ones >= int'(bus.n)) begin
      ones <= 0; zc <= 1; phase <= 1'b1; det_led <= 1'b1;
    end else if (phase && zc < int'(bus.n)) begin
      ones <= 0; zc <= zc + 1; det_led <= 1'b1;
    end else begin
      ones <= 0; phase <= 1'b0; det_led <= 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_cyc counts cycles since the accepting edge (0 = configure cycle), -1 when idle.
  int          m_cyc  = -1;
  logic [W-1:0] m_pat = '0;
  int          m_n    = 0;
  int          m_err  = 0;
  int          m_hits = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= -1; m_pat <= '0; m_n <= 0; m_err <= 0; m_hits <= 0;
    end else if (m_cyc < 0) begin
      if (bus.start) begin
        m_hits <= 0;
        if (bus.n_in != 4'd0) begin
          m_cyc <= 0; m_pat <= bus.pattern; m_n <= int'(bus.n_in); m_err <= 0;
        end else begin
          m_cyc <= W + 2; m_err <= 1;
        end
      end
    end else begin
      if (m_cyc >= 2 && m_cyc <= W + 1 && bus.led_in)
        m_hits <= (m_hits < W) ? m_hits + 1 : W;
      m_cyc <= (m_cyc == W + 2) ? -1 : m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    int exp_w;
    exp_w = (m_cyc >= 1 && m_cyc <= W) ? int'(m_pat[W - m_cyc]) : 0;
    chk("busy", int'(bus.busy), int'(m_cyc >= 0));
    chk("save", int'(bus.save), int'(m_cyc == 0));
    chk("done", int'(bus.done), int'(m_cyc == W + 2));
    chk("w", int'(bus.w), exp_w);
    chk("n", int'(bus.n), m_n);
    chk("err", int'(bus.err), m_err);
    chk("hit_count", int'(bus.hit_count), m_hits);
  end

  task automatic run(input logic [W-1:0] p, input logic [3:0] nn, input logic frc,
                     input bit repulse, input int exp_hits, input int exp_err);
    int done_n, done_k, save_n, save_k;
    done_n = 0; done_k = -1; save_n = 0; save_k = -1;
    @(negedge clk);
    bus.pattern = p; bus.n_in = nn; force_led = frc; bus.start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (repulse && k == 6) bus.start = 1'b1;
      if (repulse && k == 7) bus.start = 1'b0;
      if (bus.done) begin done_n++; done_k = k; end
      if (bus.save) begin save_n++; save_k = k; end
    end
    force_led = 1'b0;
    chk("run_hits", int'(bus.hit_count), exp_hits);
    chk("run_err", int'(bus.err), exp_err);
    chk("run_done_pulses", done_n, 1);
    chk("run_done_cycle", done_k, (nn != 4'd0) ? 18 : 0);
    chk("run_save_pulses", save_n, (nn != 4'd0) ? 1 : 0);
    chk("run_save_cycle", save_k, (nn != 4'd0) ? 0 : -1);
    chk("run_idle", int'(bus.busy), 0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.n_in = 4'd0; bus.pattern = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hits", int'(bus.hit_count), 0);
    chk("rst_n", int'(bus.n), 0);
    @(negedge clk) rst = 1'b0;

    run(16'hFC00, 4'd6, 1'b0, 1'b0, 6, 0);
    run(16'h1234, 4'd0, 1'b0, 1'b0, 0, 1);
    chk("n_hold_after_err", int'(bus.n), 6);
    run(16'hAAAA, 4'd4, 1'b0, 1'b0, 0, 0);
    run(16'h5A3C, 4'd5, 1'b1, 1'b0, 16, 0);
    run(16'hFC00, 4'd6, 1'b0, 1'b1, 6, 0);

    // start held high: runs back to back with one idle cycle between them
    dn = 0;
    @(negedge clk);
    bus.pattern = 16'hAAAA; bus.n_in = 4'd4; bus.start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 44) bus.start = 1'b0;
      if (bus.done) dn++;
    end
    chk("held_start_done_pulses", dn, 3);

    // reset during SHIFT cycle 7
    @(negedge clk);
    bus.pattern = 16'hFC00; bus.n_in = 4'd6; bus.start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    chk("pre_rst_busy", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_w", int'(bus.w), 0);
    chk("rst_mid_n", int'(bus.n), 0);
    chk("rst_mid_save", int'(bus.save), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    chk("rst_mid_err", int'(bus.err), 0);
    chk("rst_mid_hits", int'(bus.hit_count), 0);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("rst_no_done", dn, 0);
    run(16'hFC00, 4'd6, 1'b0, 1'b0, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
